regfile_n: RTL
==============

// Module: regfile_n
// PURPOSE
//  Parametrised register file, DEPTH entries x N bits, one write port and one registered read port.
//  Successor to the single N-bit enabled register: adds addressing, asynchronous reset, bulk clear,
//  per-entry written flags and write-to-read bypass.
//  Holds codewords and syndromes between the SEC-DED encoder and decoder stages.
// PARAMETERS
//  N      8  data width in bits (>=1)
//  DEPTH  4  number of entries (>=2, need not be a power of 2)
//  AW     $clog2(DEPTH)  address width (derived, not to be overridden)
// PORTS
//  CLKb   input   1      clock; all state updates on negedge CLKb
//  RSTb   input   1      reset, asynchronous assert, active-low; released synchronous to negedge CLKb upstream
//  CLR    input   1      synchronous clear of all entries and written flags
//  WE     input   1      write enable
//  WADDR  input   AW     write address
//  WD     input   N      write data
//  RE     input   1      read enable
//  RADDR  input   AW     read address
//  RD     output  N      registered read data
//  RVALID output  1      RD updated by a read issued on the previous edge
//  RHIT   output  1      entry read had been written since last reset/clear
//  WERR   output  1      registered: last WE or RE addressed an entry >= DEPTH
// BEHAVIOUR
//  Reset (RSTb=0, immediate, no clock needed): all entries=0, written flags=0, RD=0, RVALID=0, RHIT=0, WERR=0.
//  Write: on negedge with WE=1, WADDR<DEPTH, CLR=0 -> mem[WADDR]<=WD, flag[WADDR]<=1.
//  Read latency 1: on negedge with RE=1 -> RD<=mem[RADDR], RHIT<=flag[RADDR], RVALID<=1.
//  RE=0 on a negedge -> RD and RHIT hold their previous values, RVALID<=0.
//  Same-edge write and read, same address -> bypass: RD<=WD, RHIT<=1 (new data, never stale).
//  Same-edge write and read, different addresses -> independent, both complete.
//  CLR=1 on a negedge: all entries<=0, all flags<=0; any WE on that edge is dropped.
//   A read on the same edge returns RD=0, RHIT=0, RVALID=1 (clear takes precedence over bypass).
//  Out-of-range address (only when DEPTH is not a power of 2):
//   WADDR>=DEPTH -> write ignored.
//   RADDR>=DEPTH with RE=1 -> RD<=0, RHIT<=0, RVALID<=1.
//   Either case -> WERR<=1 on that edge.
//  WERR: re-evaluated on every negedge; 0 when neither port is enabled with a bad address.
//  Reset asserted mid-operation: in-flight read is discarded; RVALID=0 on the following edge
//   unless a new RE is issued after RSTb releases.
//  No other state; no combinational path from inputs to outputs.
// TESTING  (N=8, DEPTH=4 unless stated)
//  1. RSTb=0 for 2 edges, then RE=1 to each of addr 0..3 -> RD=0x00, RHIT=0, RVALID=1 each cycle.
//  2. WE=1, WADDR=2, WD=0xA5; next edge RE=1, RADDR=2 -> after that edge RD=0xA5, RHIT=1, RVALID=1;
//     an RE=0 edge follows -> RD holds 0xA5, RVALID=0.
//  3. Same edge: WE=1, WADDR=1, WD=0x3C, RE=1, RADDR=1 -> RD=0x3C, RHIT=1 immediately after that edge.
//  4. Fill 0..3 with 0x11,0x22,0x33,0x44; CLR=1 with WE=1, WADDR=0, WD=0xFF -> later reads of all
//     entries give 0x00, RHIT=0.
//  5. DEPTH=3: WE=1, WADDR=3, WD=0x77 -> WERR=1, entries unchanged; RE=1, RADDR=3 -> RD=0, RHIT=0, WERR=1.
//  6. Write 0x5A to addr 3; drop RSTb low between negedges -> RD=0, RVALID=0 without a clock edge;
//     after release, a read of addr 3 gives 0x00.

Source files
------------

// File: rtl/regfile_n.sv
// DEPTH x N register file, one write port, one registered read port.
// Negedge clocked, async active-low reset, bulk clear and write bypass.
module regfile_n #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLKb,
    input  logic          RSTb,
    input  logic          CLR,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [N-1:0]  WD,
    input  logic          RE,
    input  logic [AW-1:0] RADDR,
    output logic [N-1:0]  RD,
    output logic          RVALID,
    output logic          RHIT,
    output logic          WERR
);

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] flag_q;
    logic [DEPTH-1:0] flag_d;
    logic [N-1:0]     rd_q;
    logic [N-1:0]     rd_d;
    logic             rhit_q;
    logic             rhit_d;
    logic             rvalid_q;
    logic             rvalid_d;
    logic             werr_q;
    logic             werr_d;

    logic w_ok;
    logic r_ok;
    logic w_go;

    // Address range checks; only meaningful when DEPTH is not a power of 2
    assign w_ok = (int'(WADDR) < DEPTH);
    assign r_ok = (int'(RADDR) < DEPTH);
    assign w_go = WE && w_ok && !CLR;

    // Next state: write/clear of the array, read with bypass, error flag
    always_comb begin
        mem_d    = mem_q;
        flag_d   = flag_q;
        rd_d     = rd_q;
        rhit_d   = rhit_q;
        rvalid_d = RE;
        werr_d   = (WE && !w_ok) || (RE && !r_ok);

        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            flag_d = '0;
        end else if (w_go) begin
            mem_d[WADDR]  = WD;
            flag_d[WADDR] = 1'b1;
        end

        if (RE) begin
            if (CLR || !r_ok) begin
                rd_d   = '0;
                rhit_d = 1'b0;
            end else if (w_go && (WADDR == RADDR)) begin
                rd_d   = WD;
                rhit_d = 1'b1;
            end else begin
                rd_d   = mem_q[RADDR];
                rhit_d = flag_q[RADDR];
            end
        end
    end

    // State registers; reset discards everything including an in-flight read
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            flag_q   <= '0;
            rd_q     <= '0;
            rhit_q   <= 1'b0;
            rvalid_q <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            flag_q   <= flag_d;
            rd_q     <= rd_d;
            rhit_q   <= rhit_d;
            rvalid_q <= rvalid_d;
            werr_q   <= werr_d;
        end
    end

    assign RD     = rd_q;
    assign RHIT   = rhit_q;
    assign RVALID = rvalid_q;
    assign WERR   = werr_q;

endmodule
